fifo_uart_tx: RTL
=================

# fifo_uart_tx

Consumer for the team's 8-bit synchronous FIFO: drains bytes through the FIFO read port and serializes each one as a UART 8N1 frame on `tx`. The block sits between the FIFO read side and the device pin. It fetches a new byte only when the FIFO reports non-empty and transmission is enabled.

## Interface
Parameters:
- `CLK_DIV`, default 16: clk cycles per UART bit. Legal values are 2 or more.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tx_enable`  in  1: permits fetching a new byte. It does not abort a frame in progress.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_read_enable`  out  1: FIFO read strobe, one cycle wide per byte.
- `fifo_read_data`  in  8: FIFO read data, registered in the FIFO. It is valid the cycle after `fifo_read_enable`.
- `tx`  out  1: serial line, registered. Idles high.
- `busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse on the last cycle of the stop bit.

## Operation
States:
- IDLE: `tx`=1. Goes to FETCH when `tx_enable && !fifo_empty`.
- FETCH: `fifo_read_enable`=1 for exactly this one cycle. Goes to LOAD unconditionally.
- LOAD: captures `fifo_read_data` into an 8-bit shift register, clears the bit counter and baud counter, then goes to START.
- START: `tx`=0 for CLK_DIV cycles, then goes to DATA.
- DATA: sends 8 bits, LSB first, each held CLK_DIV cycles. The shift register shifts right at each bit boundary. A 3-bit counter tracks the bit index. After bit 7, goes to STOP.
- STOP: `tx`=1 for CLK_DIV cycles. On the last cycle, `tx_done` pulses. The next state is FETCH if `tx_enable && !fifo_empty`, otherwise IDLE.

Rules:
- Baud counter: width `$clog2(CLK_DIV)`. It counts 0 to CLK_DIV-1. The terminal count is the bit boundary. It wraps to 0 at terminal count and is held at 0 in IDLE, FETCH and LOAD.
- `fifo_read_enable` is never asserted while `fifo_empty`=1. It is never asserted in any state other than FETCH.
- `tx_enable` is sampled only in IDLE and on the last STOP cycle.
- A `fifo_empty` change during a frame has no effect until the next sample point.

## Timing
Reset values, asynchronous:
- `tx`=1, `fifo_read_enable`=0, `busy`=0, `tx_done`=0.
- State = IDLE, shift register = 0, all counters = 0.

Latency:
- From the IDLE cycle where the fetch condition is true to the first `tx`=0 is 3 cycles: FETCH, LOAD, then `tx` registers low in the first START cycle.
- A frame lasts 10×CLK_DIV cycles measured on `tx`.
- Back-to-back frames: the idle-high gap between frames is the stop bit plus 2 cycles (FETCH and LOAD). There is no IDLE cycle in between.

Boundary conditions:
- FIFO empties mid-frame: the current frame completes, then the block goes to IDLE.
- `tx_enable` drops mid-frame: the current frame completes with no new fetch.
- Reset mid-frame: `tx` returns high immediately and the partial byte is discarded. The FIFO read pointer has already advanced, so the byte is lost. The bench must check for exactly this behaviour.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, FETCH, LOAD, START, DATA, STOP),
  - `UART_DATA_W`=8,
  - `UART_FRAME_BITS`=10,
  - default `CLK_DIV`.
- Sub-module `uart_baud_cnt`: parameterized by CLK_DIV. It has inputs `clr` and `en` and outputs the terminal-count tick. The same counter is intended for reuse in a future UART RX.

## Test plan
- CLK_DIV=4, FIFO holds 0xA5, tx_enable=1.
  - Expect one `fifo_read_enable` pulse.
  - Expect `tx`, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - Expect `tx_done` on cycle 40 of the frame.
- CLK_DIV=4, FIFO holds 0x00 then 0xFF.
  - Expect back-to-back frames with a stop-bit + 2-cycle gap.
  - Expect exactly 2 read strobes, then IDLE with `busy`=0.
- `fifo_empty`=1 held, tx_enable=1 for 100 cycles: expect `fifo_read_enable` never asserted, `tx`=1, `busy`=0.
- tx_enable deasserted during DATA of byte 0x3C with more bytes queued: expect 0x3C completes, then no further reads until tx_enable returns.
- `rst_n` pulsed low at bit 3 of 0x81:
  - Expect `tx`=1 and `busy`=0 immediately.
  - After release with the FIFO non-empty, expect a clean new frame to start 3 cycles later.
- CLK_DIV=2 (minimum), byte 0x55: expect each bit held 2 cycles and a correct 20-cycle frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and frame constants shared by the TX path and a future RX path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} uart_state_e;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_CLK_DIV = 16;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port of the byte FIFO; master is the consumer issuing read strobes
interface fifo_uart_tx_if import uart_pkg::*;;
  logic fifo_empty;
  logic fifo_read_enable;
  logic [UART_DATA_W-1:0] fifo_read_data;
  modport master (input fifo_empty, input fifo_read_data, output fifo_read_enable);
  modport slave (output fifo_empty, output fifo_read_data, input fifo_read_enable);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLK_DIV-1 and ticks on the terminal count
module uart_baud_cnt #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic [$clog2(CLK_DIV)-1:0] cnt,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO and serializes each byte as a UART 8N1 frame on tx
module fifo_uart_tx import uart_pkg::*; #(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_enable,
  fifo_uart_tx_if.master fifo,
  output logic tx,
  output logic busy,
  output logic tx_done
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLK_DIV - 2);
  uart_state_e state;
  logic [UART_DATA_W-1:0] shreg;
  logic [2:0] bit_idx;
  logic [CW-1:0] baud_cnt;
  logic tick;
  logic go;
  logic cnt_run;
  assign go = tx_enable && !fifo.fifo_empty;
  assign cnt_run = state inside {START, DATA, STOP};
  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!cnt_run),
    .en(cnt_run),
    .cnt(baud_cnt),
    .tick(tick)
  );
  // tx_done is registered one cycle early so it lands on the last stop-bit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_idx <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
      fifo.fifo_read_enable <= 1'b0;
    end else begin
      fifo.fifo_read_enable <= 1'b0;
      tx_done <= state == STOP && baud_cnt == PRE_LAST;
      case (state)
        IDLE: if (go) begin
          state <= FETCH;
          busy <= 1'b1;
          fifo.fifo_read_enable <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg <= fifo.fifo_read_data;
          bit_idx <= '0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          tx <= shreg[0];
          shreg <= shreg >> 1;
          state <= DATA;
        end
        DATA: if (tick) begin
          tx <= bit_idx == 3'd7 ? 1'b1 : shreg[0];
          shreg <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          state <= bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick) begin
          state <= go ? FETCH : IDLE;
          busy <= go;
          fifo.fifo_read_enable <= go;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
